// File: rtl/ysyx_22040750_pkg.sv
// Shared types and constants for the ysyx_22040750 fetch stage.
package ysyx_22040750_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RESP = 2'd1,
    S_OUT  = 2'd2,
    S_NPC  = 2'd3
  } ifu_state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // The bus returns an aligned doubleword; pc[2] picks the 32-bit half.
  function automatic logic [31:0] sel_inst(input logic [31:0] pc, input logic [63:0] rdata);
    return pc[2] ? rdata[63:32] : rdata[31:0];
  endfunction

endpackage

// File: rtl/ysyx_22040750_if_id_reg.sv
// IF/ID pipeline register: loads only when empty, holds until decode accepts.
module ysyx_22040750_if_id_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] pc_in,
  input  logic [31:0] snpc_in,
  input  logic [31:0] inst_in,
  input  logic        exc_in,
  input  logic        id_ready,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] snpc,
  output logic [31:0] inst,
  output logic        exc
);
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d, snpc_q, snpc_d, inst_q, inst_d;
  logic        exc_q, exc_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    snpc_d  = snpc_q;
    inst_d  = inst_q;
    exc_d   = exc_q;
    if (load && !valid_q) begin
      valid_d = 1'b1;
      pc_d    = pc_in;
      snpc_d  = snpc_in;
      inst_d  = inst_in;
      exc_d   = exc_in;
    end else if (valid_q && id_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      snpc_q  <= '0;
      inst_q  <= '0;
      exc_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      snpc_q  <= snpc_d;
      inst_q  <= inst_d;
      exc_q   <= exc_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign snpc  = snpc_q;
  assign inst  = inst_q;
  assign exc   = exc_q;
endmodule

// File: rtl/ysyx_22040750_ifu.sv
// ysyx_22040750 instruction fetch unit: PC register, fetch FSM and IF/ID register.
// Define YSYX_22040750_IFU_MISALIGN_EN to report misaligned PCs as exception entries.
//   state  | meaning
//   S_REQ  | request for pc offered to imem
//   S_RESP | request accepted, waiting for read data
//   S_OUT  | IF/ID full, waiting for decode (and next PC)
//   S_NPC  | decode took the entry, waiting for next PC
module ysyx_22040750_ifu
  import ysyx_22040750_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [31:0] I_dnpc,
  input  logic        I_pc_valid,
  output logic        O_pc_ready,
  output logic        O_imem_req_valid,
  input  logic        I_imem_req_ready,
  output logic [31:0] O_imem_addr,
  input  logic        I_imem_resp_valid,
  input  logic [63:0] I_imem_rdata,
  output logic        O_IF_ID_valid,
  input  logic        I_ID_ready,
  output logic [31:0] O_IF_ID_pc,
  output logic [31:0] O_IF_ID_snpc,
  output logic [31:0] O_IF_ID_inst,
  output logic        O_IF_ID_exc
);
  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] dnpc_fix, load_inst;
  logic        misalign, if_id_load, load_exc, exc_in;

`ifdef YSYX_22040750_IFU_MISALIGN_EN
  assign misalign = (pc_q[1:0] != 2'b00);
  assign dnpc_fix = I_dnpc;
  assign exc_in   = load_exc;
`else
  assign misalign = 1'b0;
  assign dnpc_fix = I_dnpc & ~32'h3;
  assign exc_in   = 1'b0;
`endif

  assign O_pc_ready = (state_q == S_NPC) || ((state_q == S_OUT) && I_ID_ready);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_id_load = 1'b0;
    load_exc   = 1'b0;
    load_inst  = sel_inst(pc_q, I_imem_rdata);
    case (state_q)
      S_REQ: begin
        // A misaligned PC never reaches memory; it becomes a NOP carrying the exception.
        if (misalign) begin
          if_id_load = 1'b1;
          load_inst  = NOP_INST;
          load_exc   = 1'b1;
          state_d    = S_OUT;
        end else if (I_imem_req_ready) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (I_imem_resp_valid) begin
          if_id_load = 1'b1;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (I_ID_ready) state_d = I_pc_valid ? S_REQ : S_NPC;
      end
      S_NPC: begin
        if (I_pc_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
    if (O_pc_ready && I_pc_valid) pc_d = dnpc_fix;
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign O_imem_req_valid = (state_q == S_REQ) && !misalign;
  assign O_imem_addr      = {pc_q[31:3], 3'b000};

  ysyx_22040750_if_id_reg u_if_id (
    .clk      (I_clk),
    .rst      (I_rst),
    .load     (if_id_load),
    .pc_in    (pc_q),
    .snpc_in  (pc_q + 32'd4),
    .inst_in  (load_inst),
    .exc_in   (exc_in),
    .id_ready (I_ID_ready),
    .valid    (O_IF_ID_valid),
    .pc       (O_IF_ID_pc),
    .snpc     (O_IF_ID_snpc),
    .inst     (O_IF_ID_inst),
    .exc      (O_IF_ID_exc)
  );
endmodule

// File: tb/tb_ysyx_22040750_ifu.sv
// Scoreboard bench for ysyx_22040750_ifu with a delay-configurable memory model.
module tb_ysyx_22040750_ifu;
  import ysyx_22040750_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] snpc;
    logic [31:0] inst;
    logic        exc;
  } entry_t;

  logic        clk = 1'b0;
  logic        I_rst, I_pc_valid, I_ID_ready;
  logic [31:0] I_dnpc;
  logic        O_pc_ready, O_imem_req_valid, O_IF_ID_valid, O_IF_ID_exc;
  logic [31:0] O_imem_addr, O_IF_ID_pc, O_IF_ID_snpc, O_IF_ID_inst;
  wire         I_imem_req_ready, I_imem_resp_valid;
  wire  [63:0] I_imem_rdata;

  logic        mem_en = 1'b1;
  logic        mdl_req_ready = 1'b0, mdl_resp_valid = 1'b0;
  logic [63:0] mdl_rdata = '0;
  logic        man_req_ready = 1'b0, man_resp_valid = 1'b0;
  logic [63:0] man_rdata = '0;
  logic [63:0] mem_rdata_next = '0;
  int          req_wait = 0, resp_delay = 0;
  int          acc_count = 0, addr_changes = 0, pop_count = 0;
  int          n_checks = 0, n_errors = 0;
  entry_t      exp_q[$];

  assign I_imem_req_ready  = mem_en ? mdl_req_ready  : man_req_ready;
  assign I_imem_resp_valid = mem_en ? mdl_resp_valid : man_resp_valid;
  assign I_imem_rdata      = mem_en ? mdl_rdata      : man_rdata;

  always #5 clk = ~clk;

  ysyx_22040750_ifu dut (
    .I_clk(clk), .I_rst(I_rst), .I_dnpc(I_dnpc), .I_pc_valid(I_pc_valid),
    .O_pc_ready(O_pc_ready), .O_imem_req_valid(O_imem_req_valid),
    .I_imem_req_ready(I_imem_req_ready), .O_imem_addr(O_imem_addr),
    .I_imem_resp_valid(I_imem_resp_valid), .I_imem_rdata(I_imem_rdata),
    .O_IF_ID_valid(O_IF_ID_valid), .I_ID_ready(I_ID_ready),
    .O_IF_ID_pc(O_IF_ID_pc), .O_IF_ID_snpc(O_IF_ID_snpc),
    .O_IF_ID_inst(O_IF_ID_inst), .O_IF_ID_exc(O_IF_ID_exc)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic entry_t mk(input logic [31:0] pc, input logic [31:0] snpc,
                                input logic [31:0] inst, input logic exc);
    entry_t e;
    e.pc = pc; e.snpc = snpc; e.inst = inst; e.exc = exc;
    return e;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!O_IF_ID_valid && n < 60) begin
      tick();
      n++;
    end
    check_eq({tag, "_valid"}, {63'd0, O_IF_ID_valid}, 64'd1);
  endtask

  task automatic consume(input logic [31:0] d, input logic pcv);
    I_ID_ready = 1'b1;
    I_pc_valid = pcv;
    I_dnpc     = d;
    tick();
    I_ID_ready = 1'b0;
    I_pc_valid = 1'b0;
  endtask

  // Memory model: samples at negedge, drives 1 time unit later.
  initial begin : mem_model
    logic        offered, pending, prev_valid, nxt_resp;
    logic [31:0] prev_addr;
    int          cnt, wait_left;
    offered = 0; pending = 0; prev_valid = 0; nxt_resp = 0;
    prev_addr = '0; cnt = 0; wait_left = 0;
    forever begin
      @(negedge clk);
      nxt_resp = 1'b0;
      if (I_rst || !mem_en) begin
        offered = 0; pending = 0; prev_valid = 0; wait_left = req_wait;
      end else begin
        if (offered) begin
          acc_count++;
          pending = 1;
          cnt     = resp_delay;
        end
        if (O_imem_req_valid && prev_valid && O_imem_addr != prev_addr) addr_changes++;
        prev_valid = O_imem_req_valid;
        prev_addr  = O_imem_addr;
        if (pending) begin
          if (cnt == 0) begin
            nxt_resp = 1'b1;
            pending  = 0;
          end else cnt--;
        end
        if (!O_imem_req_valid) wait_left = req_wait;
        offered = 0;
        if (O_imem_req_valid && !pending) begin
          if (wait_left > 0) wait_left--;
          else offered = 1;
        end
      end
      #1;
      mdl_req_ready  = offered;
      mdl_resp_valid = nxt_resp;
      mdl_rdata      = nxt_resp ? mem_rdata_next : 64'd0;
    end
  end

  // Decode-side monitor: pops the scoreboard on every IF/ID handshake.
  initial begin : monitor
    entry_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!I_rst && O_IF_ID_valid && I_ID_ready) begin
        check_eq("entry_expected", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          pop_count++;
          check_eq("ifid_pc",   O_IF_ID_pc,   e.pc);
          check_eq("ifid_snpc", O_IF_ID_snpc, e.snpc);
          check_eq("ifid_inst", O_IF_ID_inst, e.inst);
          check_eq("ifid_exc",  O_IF_ID_exc,  e.exc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    I_rst = 1'b1; I_ID_ready = 1'b0; I_pc_valid = 1'b0; I_dnpc = '0;
    repeat (3) tick();
    check_eq("rst_valid", O_IF_ID_valid, 0);
    check_eq("rst_pc",    O_IF_ID_pc,    0);
    check_eq("rst_snpc",  O_IF_ID_snpc,  0);
    check_eq("rst_inst",  O_IF_ID_inst,  0);
    check_eq("rst_exc",   O_IF_ID_exc,   0);

    exp_q.push_back(mk(32'h8000_0000, 32'h8000_0004, 32'h0000_0013, 1'b0));
    mem_rdata_next = 64'h0000_0297_0000_0013;
    I_rst = 1'b0;
    tick();
    check_eq("first_req_valid", O_imem_req_valid, 1);
    check_eq("first_addr",      O_imem_addr,      32'h8000_0000);
    wait_valid("f0");

    exp_q.push_back(mk(32'h8000_0004, 32'h8000_0008, 32'h1234_5678, 1'b0));
    mem_rdata_next = 64'h1234_5678_9ABC_DEF0;
    consume(32'h8000_0004, 1'b1);
    check_eq("loop_req_valid", O_imem_req_valid, 1);
    check_eq("loop_addr",      O_imem_addr,      32'h8000_0000);
    wait_valid("f1");

    // Backpressure, with slow memory armed for the following fetch.
    req_wait = 3; resp_delay = 4;
    mem_rdata_next = 64'hDEAD_BEEF_0000_0297;
    I_ID_ready = 1'b0; I_pc_valid = 1'b1; I_dnpc = 32'h8000_0100;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("bp_pc_ready",  O_pc_ready,       0);
      check_eq("bp_req_valid", O_imem_req_valid, 0);
      check_eq("bp_valid",     O_IF_ID_valid,    1);
      check_eq("bp_pc",        O_IF_ID_pc,       32'h8000_0004);
      check_eq("bp_inst",      O_IF_ID_inst,     32'h1234_5678);
      tick();
    end
    acc0 = acc_count;
    exp_q.push_back(mk(32'h8000_0100, 32'h8000_0104, 32'h0000_0297, 1'b0));
    consume(32'h8000_0100, 1'b1);
    check_eq("bp_req_valid_after", O_imem_req_valid, 1);
    check_eq("bp_addr_after",      O_imem_addr,      32'h8000_0100);
    wait_valid("f2");
    check_eq("wait_one_accept",  acc_count - acc0, 1);
    check_eq("wait_addr_stable", addr_changes,     0);

    req_wait = 0; resp_delay = 0;
    mem_rdata_next = 64'h0000_0000_0000_1117;
    acc0 = acc_count;
`ifdef YSYX_22040750_IFU_MISALIGN_EN
    exp_q.push_back(mk(32'h8000_0102, 32'h8000_0106, NOP_INST, 1'b1));
    consume(32'h8000_0102, 1'b1);
    check_eq("mis_req_valid", O_imem_req_valid, 0);
    wait_valid("f3");
    check_eq("mis_no_accept", acc_count - acc0, 0);
`else
    exp_q.push_back(mk(32'h8000_0100, 32'h8000_0104, 32'h0000_1117, 1'b0));
    consume(32'h8000_0102, 1'b1);
    check_eq("mis_req_valid", O_imem_req_valid, 1);
    check_eq("mis_addr",      O_imem_addr,      32'h8000_0100);
    wait_valid("f3");
    check_eq("mis_one_accept", acc_count - acc0, 1);
`endif

    // Take the entry without a next PC, then reset in S_RESP with a stray response.
    consume(32'h0, 1'b0);
    check_eq("npc_pc_ready",  O_pc_ready,       1);
    check_eq("npc_req_valid", O_imem_req_valid, 0);
    mem_en = 1'b0;
    I_pc_valid = 1'b1; I_dnpc = 32'h8000_0200;
    tick();
    I_pc_valid = 1'b0;
    check_eq("npc_addr", O_imem_addr, 32'h8000_0200);
    man_req_ready = 1'b1;
    tick();
    man_req_ready = 1'b0;
    check_eq("resp_wait_req_valid", O_imem_req_valid, 0);
    I_rst = 1'b1;
    I_pc_valid = 1'b1; I_dnpc = 32'h8000_0300;
    tick();
    I_rst = 1'b0; I_pc_valid = 1'b0;
    tick();
    man_resp_valid = 1'b1; man_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    man_resp_valid = 1'b0;
    #1;
    check_eq("rst_mid_valid",     O_IF_ID_valid,    0);
    check_eq("rst_mid_req_valid", O_imem_req_valid, 1);
    check_eq("rst_mid_addr",      O_imem_addr,      32'h8000_0000);
    exp_q.push_back(mk(32'h8000_0000, 32'h8000_0004, 32'h0000_0013, 1'b0));
    mem_rdata_next = 64'h0000_0297_0000_0013;
    mem_en = 1'b1;
    wait_valid("f4");

    // snpc wraps at the top of the address space.
    exp_q.push_back(mk(32'hFFFF_FFFC, 32'h0000_0000, 32'hCAFE_F00D, 1'b0));
    mem_rdata_next = 64'hCAFE_F00D_1111_2222;
    consume(32'hFFFF_FFFC, 1'b1);
    check_eq("wrap_addr", O_imem_addr, 32'hFFFF_FFF8);
    wait_valid("f5");
    consume(32'h0, 1'b0);
    repeat (3) tick();
    check_eq("queue_drained", exp_q.size(), 0);
    check_eq("pop_count",     pop_count,    6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/ysyx_22040750_ifu.md
# ysyx_22040750_ifu

Instruction fetch unit of the ysyx_22040750 in-order pipeline. Holds the architectural PC and issues one instruction-memory read per instruction over a 64-bit valid/ready bus. Presents the fetched word to the decode stage through the IF/ID register. Accepts the next PC from the dnpc generator over a valid/ready handshake. Fetch is non-speculative: a new fetch starts only after the next PC has been handed over.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.

Ports:
- I_clk  in  1  clock; all state updates on posedge.
- I_rst  in  1  reset; synchronous, active-high.
- I_dnpc  in  32  next PC from the dnpc generator.
- I_pc_valid  in  1  I_dnpc is valid.
- O_pc_ready  out  1  IFU accepts I_dnpc this cycle.
- O_imem_req_valid  out  1  fetch request valid.
- I_imem_req_ready  in  1  memory accepts the request.
- O_imem_addr  out  32  8-byte aligned fetch address, {pc[31:3],3'b000}.
- I_imem_resp_valid  in  1  read data valid; single-cycle pulse.
- I_imem_rdata  in  64  read data.
- O_IF_ID_valid  out  1  IF/ID register holds a valid instruction.
- I_ID_ready  in  1  decode accepts the IF/ID contents.
- O_IF_ID_pc  out  32  PC of the held instruction.
- O_IF_ID_snpc  out  32  O_IF_ID_pc + 4.
- O_IF_ID_inst  out  32  held instruction.
- O_IF_ID_exc  out  1  held entry is an instruction-address-misaligned exception; 0 unless the macro is enabled.

## Operation
FSM states: S_REQ, S_RESP, S_OUT, S_NPC.

- **S_REQ**
  - O_imem_req_valid=1.
  - If I_imem_req_ready=1 → S_RESP.
- **S_RESP**
  - Wait for I_imem_resp_valid.
  - On the pulse: inst = pc[2] ? rdata[63:32] : rdata[31:0].
  - Load IF/ID with pc, pc+4, inst; set O_IF_ID_valid=1 → S_OUT.
- **S_OUT**
  - IF/ID contents are held stable while O_IF_ID_valid=1 and I_ID_ready=0.
  - On I_ID_ready=1: O_IF_ID_valid clears next cycle.
  - Next state:
    - If I_pc_valid=1 in the same cycle, also pc←I_dnpc → S_REQ.
    - Otherwise → S_NPC.
- **S_NPC**
  - O_pc_ready=1.
  - On I_pc_valid=1: pc←I_dnpc → S_REQ.

Rules that hold in every state:
- O_pc_ready = (state==S_NPC) | (state==S_OUT & I_ID_ready).
- I_dnpc is sampled only on the pc_valid & pc_ready handshake.
- I_imem_resp_valid outside S_RESP is ignored.
- The IF/ID register is never overwritten while O_IF_ID_valid=1.
- snpc is a 32-bit add; it wraps modulo 2^32, so 32'hFFFF_FFFC gives snpc 0.

## Timing
- Reset values:
  - pc=RESET_PC, state=S_REQ.
  - O_IF_ID_valid=0, O_IF_ID_pc=0, O_IF_ID_snpc=0, O_IF_ID_inst=0, O_IF_ID_exc=0.
  - O_imem_req_valid=1 from the first cycle after reset release.
- Minimum loop with zero-wait memory, from request accept to the next request: 3 cycles (S_REQ → S_RESP → S_OUT → S_REQ). This requires I_ID_ready and I_pc_valid both high in S_OUT.
- O_IF_ID_* change only on the cycle after the response pulse.
- Reset mid-operation:
  - Asserting I_rst in any state aborts the transaction and discards any pending response.
  - The memory side is reset by the same I_rst.
- Simultaneous I_pc_valid and I_rst: reset wins.

## Configuration
- YSYX_22040750_IFU_MISALIGN_EN **defined**:
  - In S_REQ, a pc with pc[1:0]!=0 issues no request; req_valid stays 0.
  - The next cycle loads IF/ID with pc, pc+4, inst=32'h0000_0013 (NOP) and O_IF_ID_exc=1, then goes to S_OUT.
- **Undefined**:
  - pc[1:0] is forced to 0 when loaded from I_dnpc.
  - O_IF_ID_exc is tied to 0.

## Structure
- Shared package ysyx_22040750_pkg holds:
  - FSM state encoding (2-bit).
  - NOP constant 32'h0000_0013.
  - Default RESET_PC.
- Natural sub-module: ysyx_22040750_if_id_reg.
  - Contents: the valid/ready-held pipeline register for pc, snpc, inst and exc, with load enable.
- The FSM and PC register stay in the top module.

## Test plan
- Reset release → O_imem_addr=32'h8000_0000 and req_valid=1 on the first cycle. Response rdata=64'h0000_0297_0000_0013 → O_IF_ID_inst=32'h0000_0013, pc=32'h8000_0000, snpc=32'h8000_0004.
- pc=32'h8000_0004, rdata=64'h1234_5678_9ABC_DEF0 → inst=32'h1234_5678 (upper half selected).
- Backpressure: I_ID_ready=0 for 5 cycles with I_pc_valid=1 → IF/ID contents stable, O_pc_ready=0, no new request. I_ID_ready=1 → I_dnpc=32'h8000_0100 taken in that cycle and requested the next cycle.
- Memory waits: req_ready low for 3 cycles and resp delayed 4 cycles → exactly one request accepted, O_imem_addr stable throughout, one IF/ID load.
- I_rst pulsed in S_RESP, with a response arriving 1 cycle after release → response ignored; the fetch restarts at 32'h8000_0000 with O_IF_ID_valid=0.
- Macro defined, I_dnpc=32'h8000_0102 → no memory request; O_IF_ID_exc=1, inst=32'h0000_0013, pc=32'h8000_0102. Macro undefined, same stimulus → fetch at address 32'h8000_0100 with pc=32'h8000_0100.
